// File: rtl/imem_loader_pkg.sv
// +----------------------------------------------------------------------------+
// | imem_pkg : shared encodings and defaults for the instruction-memory loader  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package imem_pkg;

  localparam logic [31:0] IMEM_BASE_ADDR = 32'h0000_0000;
  localparam int          IMEM_DEPTH     = 256;
  localparam int          WORD_BYTES     = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
// +----------------------------------------------------------------------------+
// | byte_packer : shifts bytes MSB-first into a 32-bit word, flags the 4th byte |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module byte_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word_nxt,
  output logic        o_word_full
);

  localparam int IW = $clog2(WORD_BYTES);

  logic [31:0]   r_word;
  logic [IW-1:0] r_idx;

  // Shifting left puts the first byte received in the MSB position.
  assign o_word_nxt  = {r_word[23:0], i_byte};
  assign o_word_full = i_shift && (r_idx == IW'(WORD_BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= 32'd0;
      r_idx  <= '0;
    end else if (i_clear) begin
      r_word <= 32'd0;
      r_idx  <= '0;
    end else if (i_shift) begin
      r_word <= o_word_nxt;
      r_idx  <= r_idx + IW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// +----------------------------------------------------------------------------+
// | imem_loader : byte-stream program loader that fills instruction memory and |
// |               holds the CPU until a complete image has been written        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module imem_loader
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = IMEM_BASE_ADDR,
  parameter int          DEPTH     = IMEM_DEPTH,
  parameter int          TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] words_loaded
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_byte_ready;
  logic          r_mem_we;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic          r_cpu_hold;
  logic          r_load_done;
  logic          r_load_err;
  logic [15:0]   r_words;
  logic [15:0]   r_len;
  logic [TW-1:0] r_idle;

  logic          w_accept;
  logic          w_counting;
  logic          w_timeout;
  logic [15:0]   w_len_full;
  logic          w_len_bad;
  logic [15:0]   w_words_inc;
  logic          w_start_ok;
  logic          w_pk_clear;
  logic          w_pk_shift;
  logic [31:0]   w_word_nxt;
  logic          w_word_full;

  assign w_accept    = byte_valid && r_byte_ready;
  assign w_counting  = (r_state == ST_LEN_HI) || (r_state == ST_LEN_LO) || (r_state == ST_DATA);
  assign w_timeout   = !w_accept && (r_idle == TW'(TIMEOUT - 1));
  assign w_len_full  = {r_len[15:8], byte_in};
  assign w_len_bad   = (w_len_full == 16'd0) || ({1'b0, w_len_full} > 17'(DEPTH));
  assign w_words_inc = r_words + 16'd1;
  assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
  assign w_pk_clear  = (w_state_nxt == ST_DATA) && (r_state != ST_DATA);
  assign w_pk_shift  = w_accept && (r_state == ST_DATA);

  byte_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_pk_clear),
    .i_shift     (w_pk_shift),
    .i_byte      (byte_in),
    .o_word_nxt  (w_word_nxt),
    .o_word_full (w_word_full)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) w_state_nxt = ST_LEN_HI;
      ST_LEN_HI: begin
        if (w_accept)       w_state_nxt = ST_LEN_LO;
        else if (w_timeout) w_state_nxt = ST_ERR;
      end
      ST_LEN_LO: begin
        if (w_accept)       w_state_nxt = w_len_bad ? ST_ERR : ST_DATA;
        else if (w_timeout) w_state_nxt = ST_ERR;
      end
      ST_DATA: begin
        if (w_word_full)    w_state_nxt = ST_WRITE;
        else if (w_timeout) w_state_nxt = ST_ERR;
      end
      ST_WRITE: w_state_nxt = (w_words_inc == r_len) ? ST_DONE : ST_DATA;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_byte_ready <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= BASE_ADDR;
      r_mem_wdata  <= 32'd0;
      r_cpu_hold   <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
      r_words      <= 16'd0;
      r_len        <= 16'd0;
      r_idle       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_byte_ready <= (w_state_nxt == ST_LEN_HI) || (w_state_nxt == ST_LEN_LO) ||
                      (w_state_nxt == ST_DATA);
      r_mem_we     <= (w_state_nxt == ST_WRITE);
      r_cpu_hold   <= (w_state_nxt != ST_DONE);
      r_load_done  <= (w_state_nxt == ST_DONE);
      r_load_err   <= (w_state_nxt == ST_ERR);

      if (w_state_nxt == ST_WRITE) begin
        r_mem_addr  <= BASE_ADDR + {14'd0, r_words, 2'b00};
        r_mem_wdata <= w_word_nxt;
      end

      if (w_start_ok)                r_words <= 16'd0;
      else if (r_state == ST_WRITE)  r_words <= w_words_inc;

      if (w_accept && (r_state == ST_LEN_HI)) r_len[15:8] <= byte_in;
      if (w_accept && (r_state == ST_LEN_LO)) r_len[7:0]  <= byte_in;

      if (!w_counting || w_accept || (w_state_nxt != r_state)) r_idle <= '0;
      else                                                     r_idle <= r_idle + TW'(1);
    end
  end

  assign byte_ready   = r_byte_ready;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign cpu_hold     = r_cpu_hold;
  assign load_done    = r_load_done;
  assign load_err     = r_load_err;
  assign words_loaded = r_words;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: expected writes are queued by the stimulus
// and retired by a monitor watching mem_we; status flags are checked directly.
`default_nettype none

module tb_imem_loader;

  localparam int TIMEOUT = 1024;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [15:0] words_loaded;

  int          n_vec = 0;
  int          n_err = 0;
  wr_t         exp_q[$];
  logic [7:0]  stim[$];

  imem_loader #(.BASE_ADDR(32'h0000_0000), .DEPTH(256), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_data", mem_wdata, e.data);
      end
    end
  end

  // Called at a falling edge; byte_ready seen here is what the next rising edge uses.
  task automatic send_byte(input logic [7:0] b);
    bit took;
    int guard;
    byte_in    = b;
    byte_valid = 1'b1;
    took       = 1'b0;
    guard      = 0;
    while (!took && guard < 3000) begin
      took = byte_ready;
      @(negedge clk);
      guard++;
    end
    if (!took) begin
      n_vec++;
      n_err++;
      $display("FAIL byte_accept: byte %h not taken, byte_ready=%b expected 1", b, byte_ready);
    end
  endtask

  task automatic send_all(input bit gaps);
    foreach (stim[i]) begin
      if (gaps) begin
        byte_valid = 1'b0;
        byte_in    = 8'hxx;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      send_byte(stim[i]);
    end
    byte_valid = 1'b0;
    stim.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int max_cycles);
    int n;
    n = 0;
    while (!load_done && !load_err && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (!load_done && !load_err) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_end: no done/err after %0d cycles, expected one", max_cycles);
    end
  endtask

  initial begin
    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    rst_n = 1'b1;
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_words", 32'(words_loaded), 32'd0);
    check("rst_done_err", {30'd0, load_done, load_err}, 32'd0);
    repeat (20) @(negedge clk);
    check("idle_cpu_hold", 32'(cpu_hold), 32'd1);
    check("idle_byte_ready", 32'(byte_ready), 32'd0);

    // Two-word image, valid held high
    pulse_start();
    stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h04};
    push_wr(32'h0, 32'h2008_0005);
    push_wr(32'h4, 32'hAC01_0004);
    send_all(1'b0);
    wait_end(20);
    check("img2_done", 32'(load_done), 32'd1);
    check("img2_cpu_hold", 32'(cpu_hold), 32'd0);
    check("img2_words", 32'(words_loaded), 32'd2);
    check("img2_err", 32'(load_err), 32'd0);
    check("img2_pending", 32'(exp_q.size()), 32'd0);

    // Zero length
    pulse_start();
    check("restart_cpu_hold", 32'(cpu_hold), 32'd1);
    check("restart_done", 32'(load_done), 32'd0);
    stim = '{8'h00, 8'h00};
    send_all(1'b0);
    check("len0_err", 32'(load_err), 32'd1);
    check("len0_cpu_hold", 32'(cpu_hold), 32'd1);
    check("len0_words", 32'(words_loaded), 32'd0);

    // Length above DEPTH
    pulse_start();
    check("restart_err_clr", 32'(load_err), 32'd0);
    stim = '{8'h01, 8'h01};
    send_all(1'b0);
    check("len257_err", 32'(load_err), 32'd1);
    check("len257_ready", 32'(byte_ready), 32'd0);

    // Timeout with a partial word
    pulse_start();
    stim = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC};
    send_all(1'b0);
    repeat (TIMEOUT - 10) @(negedge clk);
    check("to_not_early", 32'(load_err), 32'd0);
    wait_end(40);
    check("to_err", 32'(load_err), 32'd1);
    check("to_cpu_hold", 32'(cpu_hold), 32'd1);
    check("to_words", 32'(words_loaded), 32'd0);
    check("to_addr_hold", mem_addr, 32'h4);
    check("to_data_hold", mem_wdata, 32'hAC01_0004);

    // Four-word image with gaps on the stream
    pulse_start();
    stim = '{8'h00, 8'h04,
             8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
             8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00};
    push_wr(32'h0, 32'h1122_3344);
    push_wr(32'h4, 32'h5566_7788);
    push_wr(32'h8, 32'h99AA_BBCC);
    push_wr(32'hC, 32'hDDEE_FF00);
    send_all(1'b1);
    wait_end(20);
    check("img4_done", 32'(load_done), 32'd1);
    check("img4_words", 32'(words_loaded), 32'd4);
    check("img4_pending", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of DATA
    pulse_start();
    stim = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02};
    push_wr(32'h0, 32'hDEAD_BEEF);
    send_all(1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("arst_byte_ready", 32'(byte_ready), 32'd0);
    check("arst_mem_addr", mem_addr, 32'h0);
    check("arst_mem_wdata", mem_wdata, 32'h0);
    check("arst_words", 32'(words_loaded), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full load after reset starts again at BASE_ADDR
    pulse_start();
    stim = '{8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'hCA, 8'hFE, 8'hBA, 8'hBE,
             8'h80, 8'h00, 8'h00, 8'h01};
    push_wr(32'h0, 32'h0102_0304);
    push_wr(32'h4, 32'hCAFE_BABE);
    push_wr(32'h8, 32'h8000_0001);
    send_all(1'b0);
    wait_end(20);
    check("post_rst_done", 32'(load_done), 32'd1);
    check("post_rst_words", 32'(words_loaded), 32'd3);
    check("post_rst_cpu_hold", 32'(cpu_hold), 32'd0);
    repeat (5) @(negedge clk);
    check("final_pending", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
